// File: rtl/step_phase_decoder.sv
// -----------------------------------------------------------------------------
// step_phase_decoder
//
// Decodes the four raw phase lines of a stepper motor into a signed step
// position. The phase lines are synchronized, debounced, mapped to one of four
// legal full-step codes and tracked by a two-state FSM that counts forward and
// reverse steps and flags skipped steps and illegal codes.
//
// State table:
//   state      | meaning
//   -----------+--------------------------------------------------------------
//   ST_ACQUIRE | waiting for the first accepted legal code to lock onto
//   ST_TRACK   | locked; each accepted code is compared against the last one
//
// Ports:
//   CLK      in   single clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   PH       in   raw phase lines, bit0..bit3 = phase A..D (asynchronous)
//   CLR      in   synchronous one-cycle clear of POS, ERR and ERR_CNT
//   POS      out  two's-complement step position, wraps modulo 2^POS_W
//   STEP     out  one-cycle pulse per accepted forward or reverse step
//   DIR      out  direction of the last accepted step (1 = forward)
//   VALID    out  high while locked in ST_TRACK
//   ERR      out  sticky error flag (skipped step or illegal code in track)
//   ERR_CNT  out  saturating error count
// -----------------------------------------------------------------------------
module step_phase_decoder #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16,
    parameter int POS_W         = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       PH,
    input  logic             CLR,
    output logic [POS_W-1:0] POS,
    output logic             STEP,
    output logic             DIR,
    output logic             VALID,
    output logic             ERR,
    output logic [7:0]       ERR_CNT
);

    localparam logic [0:0] ST_ACQUIRE = 1'b0;
    localparam logic [0:0] ST_TRACK   = 1'b1;

    // The stability timer only has to hold STABLE_CYCLES-1 (see below).
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Input synchronizer
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  ph_s;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], PH};
        end
    end

    assign ph_s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Debounce
    //
    // The candidate is loaded on the edge where the synchronized value first
    // differs from it, and the down-counter is loaded with STABLE_CYCLES-1.
    // Each following edge that still sees a match either decrements or, at
    // terminal count, accepts. That gives exactly STABLE_CYCLES matching
    // samples after the load edge, and a total latency of
    // SYNC_STAGES + STABLE_CYCLES edges from the first edge that samples PH.
    // armed_q makes acceptance a single event per candidate change.
    // -------------------------------------------------------------------------
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] stab_cnt_q;
    logic             armed_q;
    logic             accept;

    assign accept = armed_q && (ph_s == cand_q) && (stab_cnt_q == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand_q     <= '0;
            stab_cnt_q <= '0;
            armed_q    <= 1'b0;
        end else if (ph_s != cand_q) begin
            cand_q     <= ph_s;
            stab_cnt_q <= CNT_LOAD;
            armed_q    <= 1'b1;
        end else if (armed_q) begin
            if (stab_cnt_q == '0) begin
                armed_q <= 1'b0;
            end else begin
                stab_cnt_q <= stab_cnt_q - 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Code decode: the four full-step codes in rotation order
    // -------------------------------------------------------------------------
    logic [1:0] cand_idx;
    logic       cand_legal;

    always_comb begin
        cand_idx   = 2'd0;
        cand_legal = 1'b1;
        case (cand_q)
            4'b0011: cand_idx = 2'd0;
            4'b1001: cand_idx = 2'd1;
            4'b1100: cand_idx = 2'd2;
            4'b0110: cand_idx = 2'd3;
            default: cand_legal = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Tracking FSM and position / error datapath
    // -------------------------------------------------------------------------
    logic [0:0]       state_q, state_nxt;
    logic [1:0]       ref_q, ref_nxt;
    logic [POS_W-1:0] pos_q, pos_nxt;
    logic             step_nxt;
    logic             dir_q, dir_nxt;
    logic             err_q, err_nxt;
    logic [7:0]       err_cnt_q, err_cnt_nxt;
    logic             err_hit;
    logic [1:0]       step_delta;

    // Distance from the reference in rotation order; the 2-bit wrap is the
    // mod-4 arithmetic (1 = forward, 3 = reverse, 2 = skipped step).
    assign step_delta = cand_idx - ref_q;

    always_comb begin
        state_nxt   = state_q;
        ref_nxt     = ref_q;
        pos_nxt     = pos_q;
        step_nxt    = 1'b0;
        dir_nxt     = dir_q;
        err_hit     = 1'b0;

        if (accept) begin
            case (state_q)
                ST_ACQUIRE: begin
                    // Illegal codes are ignored while not locked.
                    if (cand_legal) begin
                        ref_nxt   = cand_idx;
                        state_nxt = ST_TRACK;
                    end
                end
                default: begin
                    if (!cand_legal) begin
                        err_hit   = 1'b1;
                        state_nxt = ST_ACQUIRE;
                    end else begin
                        case (step_delta)
                            2'd1: begin
                                pos_nxt  = pos_q + 1'b1;
                                dir_nxt  = 1'b1;
                                step_nxt = 1'b1;
                                ref_nxt  = cand_idx;
                            end
                            2'd3: begin
                                pos_nxt  = pos_q - 1'b1;
                                dir_nxt  = 1'b0;
                                step_nxt = 1'b1;
                                ref_nxt  = cand_idx;
                            end
                            2'd2: begin
                                // Skipped step: direction is unknown, so keep
                                // POS and DIR but resync the reference.
                                err_hit = 1'b1;
                                ref_nxt = cand_idx;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end

        err_nxt     = err_q | err_hit;
        err_cnt_nxt = err_cnt_q;
        if (err_hit && (err_cnt_q != 8'hFF)) begin
            err_cnt_nxt = err_cnt_q + 1'b1;
        end

        // CLR only touches the counters and the flag; the FSM, reference and
        // STEP/DIR still follow whatever was accepted this cycle.
        if (CLR) begin
            pos_nxt     = '0;
            err_nxt     = 1'b0;
            err_cnt_nxt = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_ACQUIRE;
            ref_q     <= '0;
            pos_q     <= '0;
            STEP      <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_nxt;
            ref_q     <= ref_nxt;
            pos_q     <= pos_nxt;
            STEP      <= step_nxt;
            dir_q     <= dir_nxt;
            err_q     <= err_nxt;
            err_cnt_q <= err_cnt_nxt;
        end
    end

    assign POS     = pos_q;
    assign DIR     = dir_q;
    assign VALID   = (state_q == ST_TRACK);
    assign ERR     = err_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_step_phase_decoder.sv
// -----------------------------------------------------------------------------
// tb_step_phase_decoder
//
// Self-checking bench for step_phase_decoder with default parameters:
// a table of held phase segments with expected outputs, hand-written
// sequences for latency, CLR and reset corner cases, error-count saturation,
// and randomized segments checked each cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_step_phase_decoder;

    localparam int SS  = 2;
    localparam int ST  = 16;
    localparam int PW  = 16;
    localparam int LAT = SS + ST;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic [3:0]    PH = 4'b0000;
    logic          CLR = 1'b0;
    logic [PW-1:0] POS;
    logic          STEP;
    logic          DIR;
    logic          VALID;
    logic          ERR;
    logic [7:0]    ERR_CNT;

    step_phase_decoder #(
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(ST),
        .POS_W        (PW)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .PH     (PH),
        .CLR    (CLR),
        .POS    (POS),
        .STEP   (STEP),
        .DIR    (DIR),
        .VALID  (VALID),
        .ERR    (ERR),
        .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int step_seen = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference model ----------------
    logic [3:0] legal_codes [4];
    logic          model_on = 1'b0;
    logic          m_valid;
    int            m_ref;
    logic [PW-1:0] m_pos;
    logic          m_step;
    logic          m_dir;
    logic          m_err;
    int            m_cnt;

    typedef struct {
        int         at;
        logic [3:0] code;
    } acc_t;
    acc_t pend[$];

    task automatic model_reset();
        m_valid = 1'b0; m_ref = 0; m_pos = '0; m_step = 1'b0;
        m_dir = 1'b0; m_err = 1'b0; m_cnt = 0;
        pend.delete();
    endtask

    task automatic model_error();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
    endtask

    task automatic model_accept(input logic [3:0] code);
        int idx;
        int d;
        idx = -1;
        for (int k = 0; k < 4; k++) if (legal_codes[k] == code) idx = k;
        if (!m_valid) begin
            if (idx >= 0) begin
                m_valid = 1'b1;
                m_ref   = idx;
            end
        end else if (idx < 0) begin
            m_valid = 1'b0;
            model_error();
        end else begin
            d = (idx - m_ref + 4) % 4;
            if (d == 1) begin
                m_pos = m_pos + 1'b1; m_dir = 1'b1; m_step = 1'b1; m_ref = idx;
            end else if (d == 3) begin
                m_pos = m_pos - 1'b1; m_dir = 1'b0; m_step = 1'b1; m_ref = idx;
            end else if (d == 2) begin
                model_error();
                m_ref = idx;
            end
        end
    endtask

    task automatic model_edge(input logic clr_at_edge);
        acc_t a;
        m_step = 1'b0;
        while (pend.size() > 0 && pend[0].at == cyc) begin
            a = pend.pop_front();
            model_accept(a.code);
        end
        if (clr_at_edge) begin
            m_pos = '0; m_err = 1'b0; m_cnt = 0;
        end
    endtask

    // One clock: sample CLR as the edge will see it, observe #1 after the edge.
    task automatic tick();
        logic c;
        c = CLR;
        @(posedge CLK);
        #1;
        cyc++;
        if (STEP) step_seen++;
        if (model_on) begin
            model_edge(c);
            chk("rnd_outputs", {POS, STEP, DIR, VALID, ERR, ERR_CNT},
                {m_pos, m_step, m_dir, m_valid, m_err, 8'(m_cnt)});
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_pos"}, POS, 0);
        chk({tag, "_flags"}, {STEP, DIR, VALID, ERR}, 4'b0000);
        chk({tag, "_errcnt"}, ERR_CNT, 0);
    endtask

    // Asserts reset mid-cycle, holds PH at ph_val, releases #1 after an edge.
    task automatic do_reset(input logic [3:0] ph_val);
        #2;
        RST_N = 1'b0;
        PH    = ph_val;
        CLR   = 1'b0;
        #1;
        check_zero("rst_async");
        repeat (3) @(posedge CLK);
        #1;
        check_zero("rst_held");
        RST_N = 1'b1;
        step_seen = 0;
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        PH = code;
        repeat (n) tick();
    endtask

    // Drive code and pulse CLR on exactly the edge where it is accepted.
    task automatic step_with_clr(input logic [3:0] code);
        PH = code;
        repeat (LAT) tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
    endtask

    // ---------------- table of held segments ----------------
    typedef struct {
        logic [3:0]    ph;
        int            hold;
        logic [PW-1:0] pos;
        logic          valid;
        logic          err;
        logic          dir;
        int            cnt;
        int            steps;
    } vec_t;
    vec_t vt[13];

    initial begin
        legal_codes[0] = 4'b0011;
        legal_codes[1] = 4'b1001;
        legal_codes[2] = 4'b1100;
        legal_codes[3] = 4'b0110;

        //          ph       hold pos       vld err dir cnt steps
        vt[0]  = '{4'b0011, 30, 16'h0000, 1, 0, 0, 0, 0};
        vt[1]  = '{4'b1001, 30, 16'h0001, 1, 0, 1, 0, 1};
        vt[2]  = '{4'b1100, 30, 16'h0002, 1, 0, 1, 0, 1};
        vt[3]  = '{4'b0110, 30, 16'h0003, 1, 0, 1, 0, 1};
        vt[4]  = '{4'b0011, 30, 16'h0004, 1, 0, 1, 0, 1};
        vt[5]  = '{4'b0110, 30, 16'h0003, 1, 0, 0, 0, 1};
        vt[6]  = '{4'b1100, 30, 16'h0002, 1, 0, 0, 0, 1};
        vt[7]  = '{4'b0011, 30, 16'h0002, 1, 1, 0, 1, 0};
        vt[8]  = '{4'b1111, 30, 16'h0002, 0, 1, 0, 2, 0};
        vt[9]  = '{4'b0011, 30, 16'h0002, 1, 1, 0, 2, 0};
        vt[10] = '{4'b1001, 30, 16'h0003, 1, 1, 1, 2, 1};
        vt[11] = '{4'b1010, 30, 16'h0003, 0, 1, 1, 3, 0};
        vt[12] = '{4'b0101, 30, 16'h0003, 0, 1, 1, 3, 0};

        // ---- table-driven segments ----
        do_reset(4'b0000);
        for (int i = 0; i < 13; i++) begin
            step_seen = 0;
            hold(vt[i].ph, vt[i].hold);
            chk($sformatf("vec%0d_pos", i), POS, vt[i].pos);
            chk($sformatf("vec%0d_valid", i), VALID, vt[i].valid);
            chk($sformatf("vec%0d_err", i), ERR, vt[i].err);
            chk($sformatf("vec%0d_dir", i), DIR, vt[i].dir);
            chk($sformatf("vec%0d_errcnt", i), ERR_CNT, vt[i].cnt);
            chk($sformatf("vec%0d_steps", i), step_seen, vt[i].steps);
        end

        // ---- acquire latency from reset release ----
        do_reset(4'b0011);
        repeat (LAT) tick();
        chk("acq_valid_early", VALID, 0);
        tick();
        chk("acq_valid_on_time", VALID, 1);
        tick();
        chk("acq_steps", step_seen, 0);
        chk("acq_pos", POS, 0);

        // ---- reverse step latency and wrap below zero ----
        PH = 4'b0110;
        step_seen = 0;
        repeat (LAT) tick();
        chk("rev_step_early", STEP, 0);
        tick();
        chk("rev_step", STEP, 1);
        chk("rev_dir", DIR, 0);
        chk("rev_pos", POS, 16'hFFFF);
        tick();
        chk("rev_step_one_cycle", STEP, 0);
        hold(4'b1100, 25);
        chk("rev2_pos", POS, 16'hFFFE);
        chk("rev2_steps", step_seen, 2);

        // ---- glitch rejection, then CLR against a forward step ----
        do_reset(4'b0011);
        repeat (20) tick();
        step_seen = 0;
        hold(4'b1001, 10);
        hold(4'b0011, 30);
        chk("glitch_steps", step_seen, 0);
        chk("glitch_pos", POS, 0);
        chk("glitch_err", ERR, 0);
        hold(4'b1001, 25);
        hold(4'b1100, 25);
        hold(4'b0110, 25);
        hold(4'b0011, 25);
        hold(4'b1001, 25);
        chk("fwd5_pos", POS, 5);
        step_with_clr(4'b1100);
        chk("clr_step_pos", POS, 0);
        chk("clr_step_pulse", STEP, 1);
        chk("clr_step_dir", DIR, 1);
        repeat (5) tick();
        chk("clr_step_valid", VALID, 1);

        // ---- CLR against errors ----
        hold(4'b0011, 25);
        chk("skip_err", ERR, 1);
        chk("skip_errcnt", ERR_CNT, 1);
        chk("skip_pos", POS, 0);
        step_with_clr(4'b1100);
        chk("clr_skip_err", ERR, 0);
        chk("clr_skip_errcnt", ERR_CNT, 0);
        chk("clr_skip_valid", VALID, 1);
        hold(4'b0110, 25);
        chk("ref_resync_pos", POS, 1);
        chk("ref_resync_dir", DIR, 1);
        step_with_clr(4'b1111);
        chk("clr_ill_valid", VALID, 0);
        chk("clr_ill_err", ERR, 0);
        chk("clr_ill_errcnt", ERR_CNT, 0);
        chk("clr_ill_pos", POS, 0);

        // ---- reset mid-track and mid-debounce ----
        hold(4'b0011, 25);
        hold(4'b1001, 25);
        chk("pre_rst_pos", POS, 1);
        hold(4'b1100, 10);
        do_reset(4'b1100);
        repeat (LAT + 1) tick();
        chk("post_rst_valid", VALID, 1);
        chk("post_rst_pos", POS, 0);
        chk("post_rst_steps", step_seen, 0);
        hold(4'b1001, 25);
        chk("post_rst_rev_pos", POS, 16'hFFFF);
        chk("post_rst_rev_dir", DIR, 0);

        // ---- error counter saturation via repeated skips ----
        do_reset(4'b0011);
        repeat (LAT + 2) tick();
        for (int i = 1; i <= 258; i++) begin
            hold((i % 2) ? 4'b1100 : 4'b0011, LAT + 2);
            if (i == 254) chk("sat_errcnt_254", ERR_CNT, 254);
            if (i == 255) chk("sat_errcnt_255", ERR_CNT, 255);
        end
        chk("sat_errcnt_hold", ERR_CNT, 255);
        chk("sat_valid", VALID, 1);
        chk("sat_pos", POS, 0);

        // ---- randomized segments against the model ----
        do_reset(4'b0000);
        model_reset();
        model_on = 1'b1;
        begin
            logic [3:0] pool [12];
            logic [3:0] prev;
            logic [3:0] code;
            int len;
            pool = '{4'b0011, 4'b1001, 4'b1100, 4'b0110,
                     4'b0011, 4'b1001, 4'b1100, 4'b0110,
                     4'b1111, 4'b0101, 4'b1010, 4'b0001};
            prev = 4'b0000;
            for (int s = 0; s < 90; s++) begin
                code = prev;
                while (code == prev) code = pool[$urandom_range(0, 11)];
                prev = code;
                if (s != 89 && $urandom_range(0, 3) == 0)
                    len = $urandom_range(1, ST - 2);
                else
                    len = $urandom_range(ST + 2, ST + 12);
                PH = code;
                if (len > ST) pend.push_back('{cyc + 1 + LAT, code});
                for (int t = 0; t < len; t++) begin
                    CLR = ($urandom_range(0, 19) == 0);
                    tick();
                    CLR = 1'b0;
                end
            end
            repeat (LAT + 2) tick();
        end
        model_on = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/step_phase_decoder.md
STEP_PHASE_DECODER -- requirements
Module: step_phase_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of input synchronizer flops (min 2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 16, meaning the consecutive synchronized samples needed to accept a pattern (min 1).
REQ-003 SHALL have parameter POS_W, default 16, meaning the position counter width.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST_N, input, 1, the reset: asynchronous assert, active-low.
REQ-006 SHALL have port PH, input, 4, the raw asynchronous stepper phase lines, bit0..bit3 = phase A..D.
REQ-007 SHALL have port CLR, input, 1, a synchronous single-cycle clear of POS, ERR and ERR_CNT.
REQ-008 SHALL have port POS, output, POS_W, a two's-complement step position.
REQ-009 SHALL have port STEP, output, 1, a one-cycle pulse per accepted step.
REQ-010 SHALL have port DIR, output, 1, the direction of the last accepted step: 1 = forward, 0 = reverse.
REQ-011 SHALL have port VALID, output, 1, asserted while the decoder is locked in TRACK.
REQ-012 SHALL have port ERR, output, 1, a sticky error flag.
REQ-013 SHALL have port ERR_CNT, output, 8, a saturating error counter.

Function
REQ-014 SHALL pass PH through a SYNC_STAGES-flop synchronizer; only the synchronized value S is used downstream.
REQ-015 SHALL debounce: a candidate C is loaded whenever S != C and the stability counter is restarted; once S has equalled C for STABLE_CYCLES consecutive cycles, C is "accepted" (one event per change).
REQ-016 SHALL accept only these legal codes, with index: 4'b0011=0, 4'b1001=1, 4'b1100=2, 4'b0110=3; every other accepted code is illegal.
REQ-017 SHALL implement a two-state FSM, ACQUIRE and TRACK; reset state is ACQUIRE.
REQ-018 In ACQUIRE: an accepted legal code stores its index as REF, moves to TRACK and sets VALID=1, with no STEP and no POS change; an accepted illegal code is ignored (no ERR).
REQ-019 In TRACK, accepted index == REF+1 mod 4 SHALL cause: POS+1, DIR=1, STEP=1 for one cycle, REF updated.
REQ-020 In TRACK, accepted index == REF-1 mod 4 SHALL cause: POS-1, DIR=0, STEP=1 for one cycle, REF updated.
REQ-021 In TRACK, accepted index == REF+2 mod 4 (skipped step) SHALL cause: ERR=1, ERR_CNT+1, REF updated, POS/DIR unchanged, no STEP, remain in TRACK.
REQ-022 In TRACK, an accepted illegal code SHALL cause: ERR=1, ERR_CNT+1, next state ACQUIRE, VALID=0, POS held.
REQ-023 POS SHALL wrap modulo 2^POS_W, e.g. 0x7FFF+1 -> 0x8000 and 0x0000-1 -> 0xFFFF for POS_W=16.
REQ-024 ERR_CNT SHALL saturate at 255.
REQ-025 Latency: STEP/POS update SHALL occur exactly SYNC_STAGES+STABLE_CYCLES cycles after the first CLK edge that samples the new PH value.
REQ-026 CLR coincident with a step SHALL win: POS=0, with STEP and DIR still reflecting the step.
REQ-027 CLR coincident with an error SHALL win: ERR=0, ERR_CNT=0, while the FSM transition still occurs.
REQ-028 CLR SHALL NOT affect the FSM, REF, VALID or the debounce logic.
REQ-029 A glitch shorter than STABLE_CYCLES SHALL produce no acceptance, STEP, or ERR.

Reset
REQ-030 While RST_N=0, SHALL hold: POS=0, STEP=0, DIR=0, VALID=0, ERR=0, ERR_CNT=0, FSM=ACQUIRE, synchronizer, candidate and stability counter cleared to 0.
REQ-031 Reset asserted mid-debounce or mid-track SHALL discard all state; after release the first accepted legal code only re-acquires.

Verification
REQ-032 Reset release, PH=0011 held 20 cycles -> VALID=1 at cycle 18, STEP never pulses, POS=0.
REQ-033 Locked on 0011, PH steps 1001, 1100, 0110, 0011, each held 30 cycles -> 4 STEP pulses, DIR=1, POS=4.
REQ-034 Locked on 0011, PH=0110 held -> STEP, DIR=0, POS=0xFFFF; then PH=1100 -> POS=0xFFFE.
REQ-035 Locked on 0011, PH=1100 (skip) -> ERR=1, ERR_CNT=1, POS unchanged; then PH=1111 -> ERR_CNT=2, VALID=0.
REQ-036 Locked on 0011, PH=1001 held 10 cycles then returned to 0011 -> no STEP, POS=0; CLR pulsed together with a forward step from POS=5 -> POS=0, STEP=1.
